// File: rtl/serdesphy_pkg.sv
// Shared definitions for the SerDes PHY transmit serializer: FSM state
// encoding, default framing words and the word parity helper.
package serdesphy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'h7E;
    localparam logic [7:0] IDLE_WORD_DEFAULT = 8'hAA;

    // Even parity: the appended bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/serdesphy_tx_shifter.sv
// Slot engine for the TX serializer: holds one W-bit slot (word plus optional
// parity), shifts it out MSB first and flags the last bit of every slot.
module serdesphy_tx_shifter
    import serdesphy_pkg::*;
#(
    parameter int PARITY_EN = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_word,
    output logic       o_boundary,
    output logic       o_serial
);

    localparam int W     = 8 + PARITY_EN;
    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    logic [W-1:0]     r_shift;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [W-1:0]     w_slot;

    // Parity, when present, rides in the final bit position of the slot.
    generate
        if (PARITY_EN != 0) begin : g_par
            assign w_slot = {i_word, even_parity(i_word)};
        end else begin : g_nopar
            assign w_slot = i_word;
        end
    endgenerate

    // Reset parks the counter on the last bit so the first free cycle is a boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_cnt <= LAST;
        end else if (o_boundary) begin
            r_shift   <= w_slot;
            r_bit_cnt <= '0;
        end else begin
            r_shift   <= {r_shift[W-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    assign o_boundary = (r_bit_cnt == LAST);
    assign o_serial   = r_shift[W-1];

endmodule

// File: rtl/serdesphy_tx_serializer.sv
// TX serializer: pops bytes from a first-word-fall-through FIFO and frames
// them as SYNC + data bursts with periodic resync, filling gaps with IDLE.
module serdesphy_tx_serializer
    import serdesphy_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
    parameter logic [7:0] IDLE_WORD     = IDLE_WORD_DEFAULT,
    parameter int         SYNC_INTERVAL = 16,
    parameter int         PARITY_EN     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_enable,
    input  logic [7:0]  fifo_rd_data,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic        serial_out,
    output logic        busy,
    output logic        sync_inserted,
    output logic [15:0] tx_byte_cnt
);

    state_t      r_state;
    logic [15:0] r_byte_cnt;
    logic [15:0] r_int_cnt;

    state_t      w_next_state;
    logic [7:0]  w_load_word;
    logic        w_pop;
    logic        w_sync;
    logic        w_boundary;
    logic        w_go;
    logic        w_resync;

    assign w_go     = tx_enable && !fifo_empty;
    assign w_resync = (SYNC_INTERVAL != 0) && (r_int_cnt == 16'(SYNC_INTERVAL));

    serdesphy_tx_shifter #(
        .PARITY_EN (PARITY_EN)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .i_word     (w_load_word),
        .o_boundary (w_boundary),
        .o_serial   (serial_out)
    );

    // Slot decision: only the boundary cycle may pick a new word or pop the FIFO.
    always_comb begin
        w_next_state = r_state;
        w_load_word  = IDLE_WORD;
        w_pop        = 1'b0;
        w_sync       = 1'b0;
        if (w_boundary && !rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        w_load_word  = SYNC_WORD;
                        w_sync       = 1'b1;
                        w_next_state = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (w_go) begin
                        w_load_word  = fifo_rd_data;
                        w_pop        = 1'b1;
                        w_next_state = ST_DATA;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (!tx_enable) begin
                        w_next_state = ST_IDLE;
                    end else if (w_resync) begin
                        // Resync takes the slot even when a byte is waiting.
                        w_load_word  = SYNC_WORD;
                        w_sync       = 1'b1;
                        w_next_state = ST_SYNC;
                    end else if (!fifo_empty) begin
                        w_load_word  = fifo_rd_data;
                        w_pop        = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // FSM state plus byte and resync-interval counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_byte_cnt <= '0;
            r_int_cnt  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pop) begin
                r_byte_cnt <= r_byte_cnt + 16'd1;
            end
            if (w_boundary && (w_next_state != ST_DATA)) begin
                r_int_cnt <= '0;
            end else if (w_pop) begin
                r_int_cnt <= r_int_cnt + 16'd1;
            end
        end
    end

    assign fifo_rd_en    = w_pop;
    assign sync_inserted = w_sync;
    assign busy          = (r_state != ST_IDLE);
    assign tx_byte_cnt   = r_byte_cnt;

endmodule

// File: tb/tb_serdesphy_tx_serializer.sv
// Scoreboard bench for serdesphy_tx_serializer: three instances (default,
// SYNC_INTERVAL=4, PARITY_EN=1) share one FIFO model; the active one is
// chosen per test and its per-cycle outputs are checked against a queue.
module tb_serdesphy_tx_serializer;

    localparam int K_IDLE = 0;
    localparam int K_SYNC = 1;
    localparam int K_DATA = 2;

    typedef struct packed {
        logic        ser;
        logic        rd;
        logic        sy;
        logic        bz;
        logic [15:0] cnt;
        logic [15:0] idx;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   = 1'b1;
    logic       tx_en = 1'b0;
    int         sel   = 0;
    int         tnum  = 0;
    int         cur_w = 8;

    logic [7:0] fmem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    assign fifo_data  = fmem[rd_ptr];
    assign fifo_empty = (rd_ptr == wr_ptr);

    logic en0, en1, en2;
    assign en0 = tx_en && (sel == 0);
    assign en1 = tx_en && (sel == 1);
    assign en2 = tx_en && (sel == 2);

    logic        rd0, ser0, bz0, sy0;
    logic        rd1, ser1, bz1, sy1;
    logic        rd2, ser2, bz2, sy2;
    logic [15:0] cnt0, cnt1, cnt2;

    serdesphy_tx_serializer u_dut0 (
        .clk(clk), .rst(rst), .tx_enable(en0), .fifo_rd_data(fifo_data),
        .fifo_empty(fifo_empty), .fifo_rd_en(rd0), .serial_out(ser0),
        .busy(bz0), .sync_inserted(sy0), .tx_byte_cnt(cnt0)
    );

    serdesphy_tx_serializer #(.SYNC_INTERVAL(4)) u_dut1 (
        .clk(clk), .rst(rst), .tx_enable(en1), .fifo_rd_data(fifo_data),
        .fifo_empty(fifo_empty), .fifo_rd_en(rd1), .serial_out(ser1),
        .busy(bz1), .sync_inserted(sy1), .tx_byte_cnt(cnt1)
    );

    serdesphy_tx_serializer #(.PARITY_EN(1)) u_dut2 (
        .clk(clk), .rst(rst), .tx_enable(en2), .fifo_rd_data(fifo_data),
        .fifo_empty(fifo_empty), .fifo_rd_en(rd2), .serial_out(ser2),
        .busy(bz2), .sync_inserted(sy2), .tx_byte_cnt(cnt2)
    );

    logic        m_rd, m_ser, m_bz, m_sy;
    logic [15:0] m_cnt;
    assign m_rd  = (sel == 0) ? rd0  : (sel == 1) ? rd1  : rd2;
    assign m_ser = (sel == 0) ? ser0 : (sel == 1) ? ser1 : ser2;
    assign m_bz  = (sel == 0) ? bz0  : (sel == 1) ? bz1  : bz2;
    assign m_sy  = (sel == 0) ? sy0  : (sel == 1) ? sy1  : sy2;
    assign m_cnt = (sel == 0) ? cnt0 : (sel == 1) ? cnt1 : cnt2;

    // FIFO model: the head advances on the edge that ends a pop cycle.
    always @(posedge clk) begin
        if (m_rd && !fifo_empty) rd_ptr <= rd_ptr + 8'd1;
    end

    // Scoreboard monitor
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string nm, input logic [15:0] idx,
                       input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s test=%0d cyc=%0d got=%h exp=%h", nm, tnum, idx, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("serial_out",    e.idx, 16'(m_ser), 16'(e.ser));
            cmp("fifo_rd_en",    e.idx, 16'(m_rd),  16'(e.rd));
            cmp("sync_inserted", e.idx, 16'(m_sy),  16'(e.sy));
            cmp("busy",          e.idx, 16'(m_bz),  16'(e.bz));
            cmp("tx_byte_cnt",   e.idx, m_cnt,      e.cnt);
        end
    end

    // Expected-trace construction
    exp_t        pend;
    logic [15:0] e_cnt;
    logic [15:0] e_idx;

    task automatic push(input exp_t it);
        it.idx = e_idx;
        e_idx  = e_idx + 16'd1;
        exp_q.push_back(it);
    endtask

    // Emits n cycles of a slot; the decision flags of the previous slot's last
    // cycle are fixed up here because they depend on what this slot carries.
    task automatic slot(input int kind, input logic [7:0] b, input int n);
        logic [7:0] w;
        logic [8:0] bits;
        exp_t       it;
        w    = (kind == K_IDLE) ? 8'hAA : (kind == K_SYNC) ? 8'h7E : b;
        bits = {w, ^w};
        pend.rd = (kind == K_DATA);
        pend.sy = (kind == K_SYNC);
        push(pend);
        if (kind == K_DATA) e_cnt = e_cnt + 16'd1;
        for (int i = 0; i < n; i++) begin
            it     = '0;
            it.ser = bits[8-i];
            it.bz  = (kind != K_IDLE);
            it.cnt = e_cnt;
            if (i == cur_w - 1) pend = it;
            else push(it);
        end
    endtask

    task automatic sl(input int kind, input logic [7:0] b);
        slot(kind, b, cur_w);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fpush(input logic [7:0] b);
        fmem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    // Returns in cycle 0: the first cycle after reset release.
    task automatic do_reset(input int s, input int t);
        step(1);
        rst    = 1'b1;
        tx_en  = 1'b0;
        sel    = s;
        tnum   = t;
        cur_w  = (s == 2) ? 9 : 8;
        wr_ptr = rd_ptr;
        step(1);
        rst   = 1'b0;
        pend  = '0;
        e_cnt = '0;
        e_idx = '0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            $display("FAIL drain test=%0d remaining=%0d", tnum, exp_q.size());
            $fatal(1, "scoreboard did not drain");
        end
    endtask

    initial begin
        // Idle only: alternating pattern, no pops, counters stay zero.
        do_reset(0, 1);
        sl(K_IDLE, 8'h00); sl(K_IDLE, 8'h00); sl(K_IDLE, 8'h00);
        push(pend);
        drain();

        // Single byte burst.
        do_reset(0, 2);
        sl(K_IDLE, 8'h00); sl(K_SYNC, 8'h00); sl(K_DATA, 8'h3C);
        sl(K_IDLE, 8'h00); sl(K_IDLE, 8'h00);
        push(pend);
        step(3);
        tx_en = 1'b1;
        fpush(8'h3C);
        drain();

        // Periodic resync every 4 bytes.
        do_reset(1, 3);
        for (int b = 0; b < 10; b++) fpush(8'(b));
        sl(K_IDLE, 8'h00); sl(K_SYNC, 8'h00);
        for (int b = 0; b < 10; b++) begin
            if (b == 4 || b == 8) sl(K_SYNC, 8'h00);
            sl(K_DATA, 8'(b));
        end
        sl(K_IDLE, 8'h00); sl(K_IDLE, 8'h00);
        push(pend);
        step(3);
        tx_en = 1'b1;
        drain();

        // tx_enable dropped mid-byte, then restored.
        do_reset(0, 4);
        sl(K_IDLE, 8'h00); sl(K_SYNC, 8'h00); sl(K_DATA, 8'h5A);
        sl(K_IDLE, 8'h00); sl(K_IDLE, 8'h00);
        sl(K_SYNC, 8'h00); sl(K_DATA, 8'h11); sl(K_DATA, 8'h22);
        sl(K_IDLE, 8'h00);
        push(pend);
        step(3);
        tx_en = 1'b1;
        fpush(8'h5A); fpush(8'h11); fpush(8'h22);
        step(16);
        tx_en = 1'b0;
        step(17);
        tx_en = 1'b1;
        drain();

        // Parity slots of 9 bits.
        do_reset(2, 5);
        sl(K_IDLE, 8'h00); sl(K_SYNC, 8'h00); sl(K_DATA, 8'h07);
        sl(K_IDLE, 8'h00); sl(K_IDLE, 8'h00);
        push(pend);
        step(3);
        tx_en = 1'b1;
        fpush(8'h07);
        drain();

        // Reset in the middle of a data byte.
        do_reset(0, 6);
        sl(K_IDLE, 8'h00); sl(K_SYNC, 8'h00);
        slot(K_DATA, 8'h81, 4);
        pend  = '0;
        e_cnt = '0;
        sl(K_IDLE, 8'h00); sl(K_IDLE, 8'h00);
        sl(K_SYNC, 8'h00); sl(K_DATA, 8'h55); sl(K_IDLE, 8'h00);
        push(pend);
        step(3);
        tx_en = 1'b1;
        fpush(8'h81); fpush(8'h55);
        step(17);
        rst   = 1'b1;
        tx_en = 1'b0;
        step(1);
        rst = 1'b0;
        step(12);
        tx_en = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serdesphy_tx_serializer.md
Name: serdesphy_tx_serializer

Overview:
- Transmit-side counterpart of the receive path: pops bytes from the TX FIFO read port and frames them. Sends one serial bit per clock, MSB first.
- Inserts a sync word before each burst and every SYNC_INTERVAL data bytes. Sends an idle pattern when there is no data.
- Sits between the TX FIFO read side and the analog TX driver. Single clock domain: the serial bit clock.

Parameters:
- SYNC_WORD, 8'h7E, framing word sent before a burst and at periodic resync.
- IDLE_WORD, 8'hAA, filler word sent while idle.
- SYNC_INTERVAL, 16, data bytes between forced syncs; 0 disables periodic insertion.
- PARITY_EN, 0, 1 appends an even-parity bit to every word; slot width W = 8 + PARITY_EN.

Ports:
- clk  input  1  serial bit clock
- rst  input  1  synchronous, active-high reset
- tx_enable  input  1  allow data transmission
- fifo_rd_data  input  8  TX FIFO head byte, first-word-fall-through, valid when fifo_empty=0
- fifo_empty  input  1  TX FIFO empty flag
- fifo_rd_en  output  1  one-cycle pop strobe; byte consumed in the same cycle
- serial_out  output  1  serial bit stream to the driver
- busy  output  1  state != IDLE
- sync_inserted  output  1  one-cycle pulse when a SYNC word is loaded
- tx_byte_cnt  output  16  data bytes popped; wraps at 16'hFFFF -> 0

Behaviour:
- The only decided interface constraint: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge) gives:
  - state=IDLE, shift register=0, serial_out=0, bit_cnt=W-1
  - fifo_rd_en=0, busy=0, sync_inserted=0, tx_byte_cnt=0, interval counter=0
- Reset mid-word aborts the word immediately. A byte already popped is not resent.
- Slot timing:
  - bit_cnt counts 0..W-1. The boundary cycle is bit_cnt==W-1.
  - At the boundary the next word is loaded into the shift register and bit_cnt returns to 0. Other cycles shift left by 1.
  - serial_out = shift register MSB (registered), so a word loaded at cycle N shows its MSB at cycle N+1.
  - The first cycle after reset release is a boundary.
- Parity: when PARITY_EN=1, bit W-1 is the XOR of the 8 word bits. It applies to idle, sync and data words alike.
- States; decisions are made only at boundaries:
  - IDLE: if tx_enable && !fifo_empty, load SYNC_WORD and go to SYNC. Otherwise load IDLE_WORD.
  - SYNC: if tx_enable && !fifo_empty, pop and load fifo_rd_data, go to DATA. Otherwise load IDLE_WORD and go to IDLE.
  - DATA, in priority order:
    - !tx_enable: load IDLE_WORD, go to IDLE.
    - SYNC_INTERVAL!=0 and interval counter==SYNC_INTERVAL: load SYNC_WORD, clear the counter, go to SYNC. No pop, even if the FIFO is non-empty.
    - !fifo_empty: pop and load the byte.
    - otherwise: load IDLE_WORD, go to IDLE. End of burst, not an error.
- Pop rules:
  - fifo_rd_en is asserted only in the boundary cycle, and only with fifo_empty=0. Never two pops within one slot.
  - fifo_rd_data is sampled in the same cycle as fifo_rd_en.
  - Each pop increments tx_byte_cnt and the interval counter by 1.
- Interval counter clears on every SYNC load and on entering IDLE.
- tx_enable or fifo_empty changes mid-slot have no effect until the next boundary. The current word always completes.
- sync_inserted pulses in the boundary cycle that loads SYNC_WORD.

Decomposition:
- Package serdesphy_pkg holds:
  - state encoding: IDLE, SYNC, DATA
  - default SYNC_WORD and IDLE_WORD constants
- Sub-module serdesphy_tx_shifter: W-bit load/shift register, bit counter, parity generation, boundary flag.
- The parent holds the FSM, FIFO handshake and counters.

Test Plan:
- Reset, tx_enable=0, FIFO empty -> serial_out 1,0,1,0,... from cycle 1; fifo_rd_en never 1; busy=0; tx_byte_cnt=0.
- FIFO holds 0x3C, tx_enable=1 ->
  - idle word completes, then bits 0111_1110 (sync), then 0011_1100;
  - fifo_rd_en single pulse at the boundary ending the sync;
  - then 0xAA repeats; busy falls after the data slot; tx_byte_cnt=1; sync_inserted one pulse.
- SYNC_INTERVAL=4, FIFO preloaded 0x00..0x09 ->
  - stream is SYNC,00,01,02,03,SYNC,04..07,SYNC,08,09,IDLE;
  - sync_inserted pulses 3 times; 10 pops; no pop in a sync boundary.
- tx_enable dropped at bit 2 of byte 0x5A ->
  - all 8 bits 0101_1010 emitted, then 0xAA pattern;
  - no further pops with the FIFO still non-empty;
  - re-enable -> fresh SYNC precedes the next byte.
- PARITY_EN=1, byte 0x07 -> 9-bit slots: sync 0111_1110 then parity 0; data 0000_0111 then parity 1; idle 1010_1010 then parity 0.
- rst pulsed at bit 3 of byte 0x81 ->
  - next cycle serial_out=0, busy=0, tx_byte_cnt=0;
  - after release, idle pattern resumes; 0x81 is not re-popped; the next FIFO byte is preceded by SYNC.
